// File: rtl/serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit (0), DATA_W data bits, stop bit (1).
// Every bit is held for CLKS_PER_BIT clocks. All outputs come straight from flops.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int LSB_FIRST    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_nxt;
  logic              cur_bit, nxt_bit, bit_end, last_bit;

  // The bit on the line is always the exit end of the shift register,
  // so one shift exposes the next bit.
  assign sh_nxt   = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
  assign cur_bit  = (LSB_FIRST != 0) ? shreg[0]  : shreg[DATA_W-1];
  assign nxt_bit  = (LSB_FIRST != 0) ? sh_nxt[0] : sh_nxt[DATA_W-1];
  assign bit_end  = (cyc_cnt == CW'(CLKS_PER_BIT-1));
  assign last_bit = (bit_cnt == BW'(DATA_W-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_out   <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
            state    <= START;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            tx_out   <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            state   <= DATA;
            tx_out  <= cur_bit;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (last_bit) begin
              state  <= STOP;
              tx_out <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= sh_nxt;
              tx_out  <= nxt_bit;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            // First idle cycle carries the done pulse and reopens the handshake.
            cyc_cnt  <= '0;
            state    <= IDLE;
            tx_out   <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three parameterisations side by side, a per-cycle frame-timeline
// model for each, plus literal frame patterns for the directed cases.
module tb_serial_tx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       v    [3];
  logic [7:0] d    [3];
  logic       rdy  [3];
  logic       out  [3];
  logic       busy [3];
  logic       done [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .LSB_FIRST(1)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(d[0]), .tx_valid(v[0]),
    .tx_ready(rdy[0]), .tx_out(out[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .LSB_FIRST(0)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d[1]), .tx_valid(v[1]),
    .tx_ready(rdy[1]), .tx_out(out[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .LSB_FIRST(1)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d[2]), .tx_valid(v[2]),
    .tx_ready(rdy[2]), .tx_out(out[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model: one {out,busy,ready,done} entry per clock ----------------
  localparam logic [3:0] IDLE_E = 4'b1010;
  localparam logic [3:0] DONE_E = 4'b1011;
  int         dw  [3] = '{8, 8, 8};
  int         cpb [3] = '{4, 4, 1};
  int         lsb [3] = '{1, 0, 1};
  logic [3:0] q   [3][$];
  logic [3:0] cur [3];

  // Comparison happens on the falling edge; the model then advances using the
  // inputs that the following rising edge will sample.
  initial begin
    for (int k = 0; k < 3; k++) cur[k] = IDLE_E;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if ({out[k], busy[k], rdy[k], done[k]} !== cur[k]) begin
          fails++;
          $display("FAIL model_u%0d: got out/busy/ready/done=%b expected %b at %0t",
                   k, {out[k], busy[k], rdy[k], done[k]}, cur[k], $time);
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          q[k].delete();
          cur[k] = IDLE_E;
        end else begin
          if (v[k] && cur[k][1]) begin
            for (int i = 0; i < dw[k] + 2; i++) begin
              logic b;
              if (i == 0) b = 1'b0;
              else if (i == dw[k] + 1) b = 1'b1;
              else b = (lsb[k] != 0) ? d[k][i-1] : d[k][dw[k]-i];
              for (int c = 0; c < cpb[k]; c++) q[k].push_back({b, 3'b100});
            end
            q[k].push_back(DONE_E);
          end
          cur[k] = (q[k].size() != 0) ? q[k].pop_front() : IDLE_E;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int k, input logic [7:0] data);
    v[k] = 1'b1; d[k] = data;
    tick();
    v[k] = 1'b0;
  endtask

  task automatic capture(input int k, input int n, output logic [63:0] s);
    s = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s = {s[62:0], out[k]};
    end
  endtask

  task automatic wait_done(input int k, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[k] && n < max);
  endtask

  // Frame given in transmit order, first bit in the most significant of nb bits.
  function automatic logic [63:0] expand(input logic [15:0] fr, input int nb, input int c);
    logic [63:0] r = '0;
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < c; j++) r = {r[62:0], fr[nb-1-i]};
    return r;
  endfunction

  initial begin
    logic [63:0] s;
    int n, dcnt;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin v[k] = 1'b1; d[k] = 8'hFF; end

    // 1: reset with valid asserted
    repeat (3) tick();
    @(negedge clk);
    check("rst_out",   out[0],  1'b1);
    check("rst_ready", rdy[0],  1'b1);
    check("rst_busy",  busy[0], 1'b0);
    check("rst_done",  done[0], 1'b0);
    for (int k = 0; k < 3; k++) v[k] = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_no_frame", busy[0], 1'b0);

    // 2: 0xA5, defaults
    send(0, 8'hA5);
    capture(0, 40, s);
    check("frame_a5", s & 64'hFF_FFFF_FFFF, expand(16'b0_10100101_1, 10, 4));
    @(negedge clk);
    check("a5_done_c41",  done[0], 1'b1);
    check("a5_ready_c41", rdy[0],  1'b1);
    repeat (3) tick();

    // 3: back-to-back 0x00 then 0xFF
    v[0] = 1'b1; d[0] = 8'h00;
    tick();
    d[0] = 8'hFF;
    wait_done(0, 100, n);
    check("b2b_done1_seen", done[0], 1'b1);
    check("b2b_gap_high",   out[0],  1'b1);
    tick();
    v[0] = 1'b0;
    @(negedge clk);
    check("b2b_start2", out[0],  1'b0);
    check("b2b_busy2",  busy[0], 1'b1);
    wait_done(0, 100, n);
    check("b2b_done_spacing", 64'(1 + n), 64'd41);
    repeat (3) tick();

    // 4: MSB-first instance, 0x01
    send(1, 8'h01);
    capture(1, 40, s);
    check("frame_msb_01", s & 64'hFF_FFFF_FFFF, expand(16'b0_00000001_1, 10, 4));
    @(negedge clk);
    check("msb_done", done[1], 1'b1);
    repeat (3) tick();

    // 5: reset during data bit 3 (frame cycles 17..20)
    send(0, 8'hC3);
    repeat (17) tick();
    check("mid_busy_before", busy[0], 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out",  out[0],  1'b1);
    check("mid_rst_busy", busy[0], 1'b0);
    dcnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done[0]) dcnt++;
    end
    check("mid_rst_no_done", 64'(dcnt), 64'd0);
    tick();
    send(0, 8'h3C);
    capture(0, 40, s);
    check("frame_3c", s & 64'hFF_FFFF_FFFF, expand(16'b0_00111100_1, 10, 4));
    @(negedge clk);
    check("3c_done", done[0], 1'b1);
    repeat (3) tick();

    // 6: one clock per bit, data changed while busy
    send(2, 8'h5A);
    d[2] = 8'hFF;
    capture(2, 10, s);
    check("frame_5a_cpb1", s & 64'h3FF, expand(16'b0_01011010_1, 10, 1));
    @(negedge clk);
    check("cpb1_done", done[2], 1'b1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
